// File: rtl/mem_sram_responder.sv
// mem_sram_responder: MEM-protocol slave on a word-addressed SRAM with fixed read latency,
// bounded outstanding requests, byte-enable writes and error responses outside the window.
module mem_sram_responder #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DEPTH           = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    LATENCY         = 1,
  parameter int                    MAX_OUTSTANDING = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_mem_req,
  output logic                  s_mem_gnt,
  input  logic [ADDR_WIDTH-1:0] s_mem_addr,
  input  logic                  s_mem_we,
  input  logic [3:0]            s_mem_be,
  input  logic [DATA_WIDTH-1:0] s_mem_wdata,
  output logic                  s_mem_valid,
  output logic [DATA_WIDTH-1:0] s_mem_rdata,
  output logic                  s_mem_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_cnt;
  logic                  r_v [LATENCY];
  logic                  r_e [LATENCY];
  logic [DATA_WIDTH-1:0] r_d [LATENCY];
  logic [ADDR_WIDTH-1:0] w_off;
  logic [AW-1:0]         w_idx;
  logic                  w_in, w_acc, w_unused;
  // BASE_ADDR is window-aligned, so the offset wraps high for addresses below it
  assign w_off       = s_mem_addr - BASE_ADDR;
  assign w_in        = ~|w_off[ADDR_WIDTH-1:AW+2];
  assign w_idx       = w_off[AW+1:2];
  assign w_unused    = ^w_off[1:0];
  assign s_mem_gnt   = rst_ni & s_mem_req & (r_cnt < CW'(MAX_OUTSTANDING));
  assign w_acc       = s_mem_gnt;
  assign s_mem_valid = r_v[LATENCY-1];
  assign s_mem_error = r_e[LATENCY-1];
  assign s_mem_rdata = r_d[LATENCY-1];
  always_ff @(posedge clk_i)
    if (w_acc & s_mem_we & w_in)
      for (int i = 0; i < 4; i++)
        if (s_mem_be[i]) r_mem[w_idx][8*i +: 8] <= s_mem_wdata[8*i +: 8];
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_cnt <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_v[k] <= 1'b0;
        r_e[k] <= 1'b0;
        r_d[k] <= '0;
      end
    end else begin
      r_cnt <= r_cnt + CW'(w_acc) - CW'(r_v[LATENCY-1]);
      r_v[0] <= w_acc;
      r_e[0] <= w_acc & ~w_in;
      r_d[0] <= (w_acc & ~s_mem_we & w_in) ? r_mem[w_idx] : '0;
      for (int k = 1; k < LATENCY; k++) begin
        r_v[k] <= r_v[k-1];
        r_e[k] <= r_e[k-1];
        r_d[k] <= r_d[k-1];
      end
    end
endmodule
